pc_sequencer: RTL and testbench

- Parametrised next-generation program counter for the downsampling processor control path.
- Adds relative branching, subroutine CALL/RET with a hardware return-address stack, and sticky stack-fault flags on top of increment/absolute-branch sequencing.
- Sits between the control unit (which drives the control strobes) and instruction memory (which consumes addr_out).

---
 rtl/pc_sequencer_if.sv | 45 ++++
 rtl/pc_sequencer.sv | 147 ++++++++++++++
 tb/tb_pc_sequencer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// -----------------------------------------------------------------------------
// pc_sequencer_if
// Bundle between the control unit and the program-counter sequencer.
//
// Signals:
//   PCI, BRANCH, BR_REL, CALL, RET  control strobes (control unit -> sequencer)
//   addr_in      [ADDR_W]           branch/call target or relative offset
//   addr_out     [ADDR_W]           current instruction address
//   stack_cnt    [CNT_W]            occupied return-address entries
//   stack_full, stack_empty         stack occupancy flags
//   ovf_err, unf_err                sticky stack fault flags
//
// Modports:
//   master  control-unit side (drives strobes, observes status)
//   slave   sequencer side
// -----------------------------------------------------------------------------
interface pc_sequencer_if #(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned STACK_DEPTH = 4
);
   localparam int unsigned CNT_W = $clog2(STACK_DEPTH) + 1;

   logic              PCI;
   logic              BRANCH;
   logic              BR_REL;
   logic              CALL;
   logic              RET;
   logic [ADDR_W-1:0] addr_in;
   logic [ADDR_W-1:0] addr_out;
   logic [CNT_W-1:0]  stack_cnt;
   logic              stack_full;
   logic              stack_empty;
   logic              ovf_err;
   logic              unf_err;

   modport master (
      output PCI, BRANCH, BR_REL, CALL, RET, addr_in,
      input  addr_out, stack_cnt, stack_full, stack_empty, ovf_err, unf_err
   );

   modport slave (
      input  PCI, BRANCH, BR_REL, CALL, RET, addr_in,
      output addr_out, stack_cnt, stack_full, stack_empty, ovf_err, unf_err
   );
endinterface

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Program counter with increment, absolute/relative branch, and CALL/RET
// backed by a hardware return-address stack with sticky fault flags.
//
// Ports:
//   clk    rising-edge clock
//   RST_N  asynchronous active-low reset
//   bus    pc_sequencer_if.slave: control strobes and addr_in in; addr_out,
//          stack_cnt, stack_full, stack_empty, ovf_err, unf_err out
//
// Strobe priority: RET > CALL > BRANCH > PCI > hold. Every update lands on
// addr_out one edge after the strobes are sampled.
// -----------------------------------------------------------------------------
module pc_sequencer #(
   parameter int unsigned      ADDR_W      = 8,
   parameter int unsigned      STACK_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
   input logic           clk,
   input logic           RST_N,
   pc_sequencer_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(STACK_DEPTH) + 1;
   localparam int unsigned PTR_W = $clog2(STACK_DEPTH);

   // Winning operation after priority resolution
   typedef enum logic [2:0] {
      OpHold,
      OpInc,
      OpBranch,
      OpCall,
      OpRet
   } op_e;

   // State
   logic [ADDR_W-1:0] r_addr;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_ovf;
   logic              r_unf;
   logic [ADDR_W-1:0] r_stack [STACK_DEPTH];

   // Next-state and decode
   op_e               w_op;
   logic [ADDR_W-1:0] w_addr_nxt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              w_ovf_nxt;
   logic              w_unf_nxt;
   logic              w_push;
   logic [ADDR_W-1:0] w_push_data;
   logic [PTR_W-1:0]  w_push_idx;
   logic [PTR_W-1:0]  w_top_idx;
   logic              w_full;
   logic              w_empty;

   assign w_full  = (r_cnt == CNT_W'(STACK_DEPTH));
   assign w_empty = (r_cnt == '0);

   // Push lands at entry stack_cnt; top of stack is entry stack_cnt-1.
   // Both are only used when the count is in range, so truncation is safe.
   assign w_push_idx  = r_cnt[PTR_W-1:0];
   assign w_top_idx   = PTR_W'(r_cnt - CNT_W'(1));
   assign w_push_data = r_addr + ADDR_W'(1);

   // Priority decode: lower-priority strobes are ignored entirely
   always_comb begin
      w_op = OpHold;
      if (bus.RET) begin
         w_op = OpRet;
      end else if (bus.CALL) begin
         w_op = OpCall;
      end else if (bus.BRANCH) begin
         w_op = OpBranch;
      end else if (bus.PCI) begin
         w_op = OpInc;
      end
   end

   always_comb begin
      w_addr_nxt = r_addr;
      w_cnt_nxt  = r_cnt;
      w_ovf_nxt  = r_ovf;
      w_unf_nxt  = r_unf;
      w_push     = 1'b0;

      unique case (w_op)
         OpRet: begin
            if (w_empty) begin
               w_unf_nxt = 1'b1;
            end else begin
               w_addr_nxt = r_stack[w_top_idx];
               w_cnt_nxt  = r_cnt - CNT_W'(1);
            end
         end
         OpCall: begin
            if (w_full) begin
               w_ovf_nxt = 1'b1;
            end else begin
               w_push     = 1'b1;
               w_addr_nxt = bus.addr_in;
               w_cnt_nxt  = r_cnt + CNT_W'(1);
            end
         end
         OpBranch: begin
            // Relative offset is two's complement; modular add handles sign
            w_addr_nxt = bus.BR_REL ? (r_addr + bus.addr_in) : bus.addr_in;
         end
         OpInc: begin
            w_addr_nxt = r_addr + ADDR_W'(1);
         end
         OpHold: begin
            w_addr_nxt = r_addr;
         end
         default: begin
            w_addr_nxt = r_addr;
         end
      endcase
   end

   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N) begin
         r_addr <= RESET_ADDR;
         r_cnt  <= '0;
         r_ovf  <= 1'b0;
         r_unf  <= 1'b0;
      end else begin
         r_addr <= w_addr_nxt;
         r_cnt  <= w_cnt_nxt;
         r_ovf  <= w_ovf_nxt;
         r_unf  <= w_unf_nxt;
      end
   end

   // Stack storage needs no reset: entries above stack_cnt are never read
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_stack[w_push_idx] <= w_push_data;
      end
   end

   assign bus.addr_out    = r_addr;
   assign bus.stack_cnt   = r_cnt;
   assign bus.stack_full  = w_full;
   assign bus.stack_empty = w_empty;
   assign bus.ovf_err     = r_ovf;
   assign bus.unf_err     = r_unf;
endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

   typedef struct {
      logic       pci;
      logic       branch;
      logic       br_rel;
      logic       call;
      logic       ret;
      logic [7:0] addr_in;
      logic [7:0] exp_addr;
      int         exp_cnt;
      logic       exp_ovf;
      logic       exp_unf;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   pc_sequencer_if #(.ADDR_W(ADDR_W), .STACK_DEPTH(DEPTH)) bus ();

   pc_sequencer #(
      .ADDR_W(ADDR_W),
      .STACK_DEPTH(DEPTH),
      .RESET_ADDR(8'h00)
   ) dut (
      .clk(clk),
      .RST_N(rst_n),
      .bus(bus)
   );

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_state(input string tag, input logic [7:0] e_addr, input int e_cnt,
                              input logic e_ovf, input logic e_unf);
      check({tag, " addr"}, int'(bus.addr_out), int'(e_addr));
      check({tag, " cnt"}, int'(bus.stack_cnt), e_cnt);
      check({tag, " full"}, int'(bus.stack_full), int'(e_cnt == DEPTH));
      check({tag, " empty"}, int'(bus.stack_empty), int'(e_cnt == 0));
      check({tag, " ovf"}, int'(bus.ovf_err), int'(e_ovf));
      check({tag, " unf"}, int'(bus.unf_err), int'(e_unf));
   endtask

   task automatic add(input logic pci, input logic br, input logic rel, input logic call,
                      input logic ret, input logic [7:0] ain, input logic [7:0] eaddr,
                      input int ecnt, input logic eovf, input logic eunf);
      vec_t v;
      v.pci = pci; v.branch = br; v.br_rel = rel; v.call = call; v.ret = ret;
      v.addr_in = ain; v.exp_addr = eaddr; v.exp_cnt = ecnt;
      v.exp_ovf = eovf; v.exp_unf = eunf;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic pci, input logic br, input logic rel, input logic call,
                        input logic ret, input logic [7:0] ain);
      bus.PCI = pci; bus.BRANCH = br; bus.BR_REL = rel; bus.CALL = call; bus.RET = ret;
      bus.addr_in = ain;
   endtask

   initial begin
      //   pci br rel call ret ain    addr   cnt ovf unf
      add(1, 0, 0, 0, 0, 8'h00, 8'h01, 0, 0, 0);
      add(1, 0, 0, 0, 0, 8'h00, 8'h02, 0, 0, 0);
      add(1, 0, 0, 0, 0, 8'h00, 8'h03, 0, 0, 0);
      add(0, 0, 0, 0, 0, 8'h55, 8'h03, 0, 0, 0);  // hold
      add(0, 1, 0, 0, 0, 8'hFF, 8'hFF, 0, 0, 0);
      add(1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);  // wrap
      add(0, 1, 0, 0, 0, 8'h10, 8'h10, 0, 0, 0);
      add(0, 1, 1, 0, 0, 8'hFC, 8'h0C, 0, 0, 0);  // -4
      add(0, 1, 1, 0, 0, 8'h05, 8'h11, 0, 0, 0);
      add(0, 1, 0, 0, 0, 8'h80, 8'h80, 0, 0, 0);
      add(0, 1, 0, 0, 0, 8'h20, 8'h20, 0, 0, 0);
      add(0, 0, 0, 1, 0, 8'h40, 8'h40, 1, 0, 0);
      add(0, 0, 0, 1, 0, 8'h60, 8'h60, 2, 0, 0);
      add(0, 0, 0, 0, 1, 8'h00, 8'h41, 1, 0, 0);
      add(0, 0, 0, 0, 1, 8'h00, 8'h21, 0, 0, 0);
      add(0, 1, 0, 0, 0, 8'h30, 8'h30, 0, 0, 0);
      add(0, 0, 0, 1, 0, 8'hA0, 8'hA0, 1, 0, 0);
      add(0, 0, 0, 1, 0, 8'hB0, 8'hB0, 2, 0, 0);
      add(0, 0, 0, 1, 0, 8'hC0, 8'hC0, 3, 0, 0);
      add(0, 0, 0, 1, 0, 8'hD0, 8'hD0, 4, 0, 0);
      add(0, 0, 0, 1, 0, 8'hE0, 8'hD0, 4, 1, 0);  // overflow
      add(0, 0, 0, 0, 1, 8'h00, 8'hC1, 3, 1, 0);
      add(0, 0, 0, 0, 1, 8'h00, 8'hB1, 2, 1, 0);
      add(0, 0, 0, 0, 1, 8'h00, 8'hA1, 1, 1, 0);
      add(0, 0, 0, 0, 1, 8'h00, 8'h31, 0, 1, 0);
      add(0, 0, 0, 0, 1, 8'h00, 8'h31, 0, 1, 1);  // underflow
      add(1, 1, 1, 1, 0, 8'h50, 8'h50, 1, 1, 1);  // CALL wins
      add(0, 0, 0, 1, 1, 8'h77, 8'h32, 0, 1, 1);  // RET wins
      add(1, 0, 1, 0, 0, 8'h40, 8'h33, 0, 1, 1);  // BR_REL ignored
      add(0, 1, 1, 0, 0, 8'hF0, 8'h23, 0, 1, 1);

      drive(0, 0, 0, 0, 0, 8'h00);
      #12;
      check_state("reset", 8'h00, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      foreach (vecs[i]) begin
         drive(vecs[i].pci, vecs[i].branch, vecs[i].br_rel, vecs[i].call, vecs[i].ret,
               vecs[i].addr_in);
         @(posedge clk);
         #1;
         check_state($sformatf("v%0d", i), vecs[i].exp_addr, vecs[i].exp_cnt,
                     vecs[i].exp_ovf, vecs[i].exp_unf);
      end

      // Two CALLs, then an asynchronous reset pulse between edges
      drive(0, 0, 0, 1, 0, 8'h90);
      @(posedge clk);
      #1;
      check_state("call1", 8'h90, 1, 1, 1);
      drive(0, 0, 0, 1, 0, 8'h95);
      @(posedge clk);
      #1;
      check_state("call2", 8'h95, 2, 1, 1);
      drive(0, 0, 0, 0, 0, 8'h00);
      #1;
      rst_n = 1'b0;
      #1;
      check_state("async_rst", 8'h00, 0, 0, 0);
      #1;
      rst_n = 1'b1;
      drive(0, 0, 0, 0, 1, 8'h00);
      @(posedge clk);
      #1;
      check_state("ret_after_rst", 8'h00, 0, 0, 1);

      // Stack still works after reset
      drive(0, 0, 0, 1, 0, 8'hC8);
      @(posedge clk);
      #1;
      check_state("post_call", 8'hC8, 1, 0, 1);
      drive(0, 0, 0, 0, 1, 8'h00);
      @(posedge clk);
      #1;
      check_state("post_ret", 8'h01, 0, 0, 1);
      drive(0, 0, 0, 0, 0, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
